// File: rtl/cpu_multicycle_control.sv
// Multi-cycle sequencing controller: fetch/decode/execute/memory/writeback
// over a ready/valid memory port, with illegal-opcode and timeout traps.
package cpu_multicycle_pkg;
    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE
    } instruction_type_t;

    typedef enum logic [3:0] {
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_OP,
        CL_OP_IMM,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_SYSTEM,
        CL_MISC_MEM
    } op_class_t;
endpackage

module cpu_multicycle_control
    import cpu_multicycle_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              mem_ready,
    input  logic              alu_equal,
    input  logic              alu_less_than,
    input  logic              alu_less_than_u,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_write,
    output logic              reg_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output instruction_type_t instruction_type,
    output logic              illegal,
    output logic              bus_error,
    output logic [CNT_W-1:0]  instret
);
    localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t            state, state_nxt;
    op_class_t         cls_q, cls_nxt, dec_cls;
    instruction_type_t type_q, type_nxt, dec_type;
    logic              taken_q, taken_nxt;
    logic [TW-1:0]     wait_q, wait_nxt, wait_inc;
    logic [CNT_W-1:0]  instret_q, instret_nxt;
    logic              illegal_q, illegal_nxt;
    logic              bus_q, bus_nxt;
    logic              dec_ok, br_cond, timeout_hit;

    wire [6:0] opcode = instruction[6:0];
    wire [2:0] funct3 = instruction[14:12];

    logic unused_bits;
    assign unused_bits = ^{instruction[31:15], instruction[11:7]};

    assign instruction_type = type_q;
    assign illegal          = illegal_q;
    assign bus_error        = bus_q;
    assign instret          = instret_q;

    assign wait_inc    = wait_q + TW'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) &&
                         (wait_inc == TW'(MEM_TIMEOUT));

    always_comb begin
        dec_ok   = 1'b1;
        dec_type = R_TYPE;
        dec_cls  = CL_OP;
        unique case (opcode)
            7'b0000011: begin dec_type = I_TYPE; dec_cls = CL_LOAD;     end
            7'b0010011: begin dec_type = I_TYPE; dec_cls = CL_OP_IMM;   end
            7'b1100111: begin dec_type = I_TYPE; dec_cls = CL_JALR;     end
            7'b1110011: begin dec_type = I_TYPE; dec_cls = CL_SYSTEM;   end
            7'b0001111: begin dec_type = I_TYPE; dec_cls = CL_MISC_MEM; end
            7'b0100011: begin dec_type = S_TYPE; dec_cls = CL_STORE;    end
            7'b0110011: begin dec_type = R_TYPE; dec_cls = CL_OP;       end
            7'b0110111: begin dec_type = U_TYPE; dec_cls = CL_LUI;      end
            7'b0010111: begin dec_type = U_TYPE; dec_cls = CL_AUIPC;    end
            7'b1101111: begin dec_type = J_TYPE; dec_cls = CL_JAL;      end
            7'b1100011: begin
                dec_type = B_TYPE;
                dec_cls  = CL_BRANCH;
                dec_ok   = (funct3[2:1] != 2'b01);
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        unique case (funct3)
            3'b000:  br_cond = alu_equal;
            3'b001:  br_cond = !alu_equal;
            3'b100:  br_cond = alu_less_than;
            3'b101:  br_cond = !alu_less_than;
            3'b110:  br_cond = alu_less_than_u;
            3'b111:  br_cond = !alu_less_than_u;
            default: br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_START;
            cls_q     <= CL_OP;
            type_q    <= R_TYPE;
            taken_q   <= 1'b0;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cls_q     <= cls_nxt;
            type_q    <= type_nxt;
            taken_q   <= taken_nxt;
            wait_q    <= wait_nxt;
            instret_q <= instret_nxt;
            illegal_q <= illegal_nxt;
            bus_q     <= bus_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cls_nxt     = cls_q;
        type_nxt    = type_q;
        taken_nxt   = taken_q;
        wait_nxt    = '0;
        instret_nxt = instret_q;
        illegal_nxt = illegal_q;
        bus_nxt     = bus_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        unique case (state)
            S_START: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    bus_nxt   = 1'b1;
                    state_nxt = S_TRAP;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            S_DECODE: begin
                if (!dec_ok) begin
                    illegal_nxt = 1'b1;
                    state_nxt   = S_TRAP;
                end else begin
                    type_nxt  = dec_type;
                    cls_nxt   = dec_cls;
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                taken_nxt = (cls_q == CL_BRANCH) && br_cond;
                if (cls_q == CL_LOAD || cls_q == CL_STORE)
                    state_nxt = S_MEMORY;
                else
                    state_nxt = S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CL_STORE);
                if (mem_ready) begin
                    state_nxt = S_WRITEBACK;
                end else if (timeout_hit) begin
                    bus_nxt   = 1'b1;
                    state_nxt = S_TRAP;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            S_WRITEBACK: begin
                pc_write    = 1'b1;
                instret_nxt = instret_q + CNT_W'(1);
                reg_write   = cls_q inside {CL_OP, CL_OP_IMM, CL_LOAD,
                                            CL_LUI, CL_AUIPC, CL_JAL,
                                            CL_JALR};
                if (cls_q == CL_JALR)
                    pc_src = 2'd2;
                else if (cls_q == CL_JAL || taken_q)
                    pc_src = 2'd1;
                state_nxt = S_FETCH;
            end
            S_TRAP: state_nxt = S_TRAP;
            default: state_nxt = S_START;
        endcase
    end
endmodule
